// File: rtl/counter_prescaled_if.sv
// counter_prescaled_if
//   Bundles the control inputs and count outputs of counter_prescaled.
//   Protocol: there is no valid/ready pair; en and dir are levels, load is a
//   single-cycle strobe sampled on posedge clk, and tick/ovf are one-cycle
//   pulses aligned with the count value they describe.
//   Signals:
//     en    control  count enable (prescaler and counter hold while low)
//     dir   control  1 = count up, 0 = count down
//     load  control  synchronous parallel load strobe
//     din   control  load value (N bits)
//     count status   registered count (N bits)
//     leds  status   top NLEDS bits of count
//     tick  status   pulse: count stepped on the previous edge
//     ovf   status   pulse: previous step wrapped or was clipped
//   Modports: master drives controls (bench / upstream logic), slave is the counter.
interface counter_prescaled_if #(
  parameter int N     = 8,
  parameter int NLEDS = 5
);
  logic             en;
  logic             dir;
  logic             load;
  logic [N-1:0]     din;
  logic [N-1:0]     count;
  logic [NLEDS-1:0] leds;
  logic             tick;
  logic             ovf;

  modport master (
    output en, dir, load, din,
    input  count, leds, tick, ovf
  );

  modport slave (
    input  en, dir, load, din,
    output count, leds, tick, ovf
  );
endinterface

// File: rtl/counter_prescaled.sv
// counter_prescaled
//   N-bit up/down counter advanced once per DIV enabled clocks by an internal
//   prescaler. Supports parallel load, direction control and wrap or
//   saturate behaviour at the ends of the range. Emits a tick pulse for each
//   step and an ovf pulse when a step wrapped (MODE_SAT=0) or was clipped
//   (MODE_SAT=1). leds mirrors the NLEDS most significant count bits.
//   Ports:
//     clk  in   system clock
//     rst  in   synchronous reset, active-high (highest priority)
//     bus  slave modport of counter_prescaled_if (en, dir, load, din in;
//          count, leds, tick, ovf out)
//   Edge priority: rst > load > step.
module counter_prescaled #(
  parameter int N        = 8,
  parameter int DIV      = 4,
  parameter int NLEDS    = 5,
  parameter bit MODE_SAT = 1'b0
) (
  input logic                clk,
  input logic                rst,
  counter_prescaled_if.slave bus
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  logic [PW-1:0] pre;
  logic [N-1:0]  count_q;
  logic          tick_q;
  logic          ovf_q;

  logic          pre_last;
  logic          at_top;
  logic          at_bot;
  logic          at_end;
  logic [N-1:0]  count_step;

  // With DIV=1 PRE_LAST is zero and pre never leaves zero, so every enabled
  // edge is a step edge.
  assign pre_last = (pre == PRE_LAST);
  assign at_top   = (count_q == {N{1'b1}});
  assign at_bot   = (count_q == {N{1'b0}});
  // at_end: this step would leave the range in the current direction.
  assign at_end   = bus.dir ? at_top : at_bot;

  always_comb begin
    count_step = count_q;
    if (MODE_SAT && at_end) begin
      count_step = count_q;
    end else if (bus.dir) begin
      count_step = count_q + N'(1);
    end else begin
      count_step = count_q - N'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      pre     <= '0;
      tick_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (bus.load) begin
      count_q <= bus.din;
      pre     <= '0;
      tick_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (bus.en) begin
      if (pre_last) begin
        pre     <= '0;
        count_q <= count_step;
        tick_q  <= 1'b1;
        // Wrapping and clipping both happen exactly when at_end is set.
        ovf_q   <= at_end;
      end else begin
        pre     <= pre + PW'(1);
        tick_q  <= 1'b0;
        ovf_q   <= 1'b0;
      end
    end else begin
      tick_q <= 1'b0;
      ovf_q  <= 1'b0;
    end
  end

  assign bus.count = count_q;
  assign bus.leds  = count_q[N-1 -: NLEDS];
  assign bus.tick  = tick_q;
  assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_counter_prescaled.sv
module tb_counter_prescaled;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst  = 1'b1;
  logic       en   = 1'b0;
  logic       dir  = 1'b1;
  logic       load = 1'b0;
  logic [7:0] din  = 8'h00;

  // u0: DIV=4 wrap, u1: DIV=4 saturate, u2: DIV=1 saturate with one LED
  counter_prescaled_if #(.N(8), .NLEDS(5)) if0 ();
  counter_prescaled_if #(.N(8), .NLEDS(5)) if1 ();
  counter_prescaled_if #(.N(8), .NLEDS(1)) if2 ();

  assign if0.en = en; assign if0.dir = dir; assign if0.load = load; assign if0.din = din;
  assign if1.en = en; assign if1.dir = dir; assign if1.load = load; assign if1.din = din;
  assign if2.en = en; assign if2.dir = dir; assign if2.load = load; assign if2.din = din;

  counter_prescaled #(.N(8), .DIV(4), .NLEDS(5), .MODE_SAT(1'b0)) u0 (.clk(clk), .rst(rst), .bus(if0));
  counter_prescaled #(.N(8), .DIV(4), .NLEDS(5), .MODE_SAT(1'b1)) u1 (.clk(clk), .rst(rst), .bus(if1));
  counter_prescaled #(.N(8), .DIV(1), .NLEDS(1), .MODE_SAT(1'b1)) u2 (.clk(clk), .rst(rst), .bus(if2));

  logic [7:0] a_count[3];
  logic [7:0] a_leds[3];
  logic       a_tick[3];
  logic       a_ovf[3];
  assign a_count[0] = if0.count; assign a_leds[0] = {3'b000, if0.leds};
  assign a_count[1] = if1.count; assign a_leds[1] = {3'b000, if1.leds};
  assign a_count[2] = if2.count; assign a_leds[2] = {7'b0000000, if2.leds};
  assign a_tick[0] = if0.tick; assign a_ovf[0] = if0.ovf;
  assign a_tick[1] = if1.tick; assign a_ovf[1] = if1.ovf;
  assign a_tick[2] = if2.tick; assign a_ovf[2] = if2.ovf;

  // ---------------- scoreboard bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_on   = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- behavioural reference model ----------------
  // Counts enabled edges since the last reset/load; every DIV-th one is a step.
  int div_p[3] = '{4, 4, 1};
  bit sat_p[3] = '{1'b0, 1'b1, 1'b1};
  int nl_p[3]  = '{5, 5, 1};
  int m_count[3];
  int m_phase[3];
  bit m_tick[3];
  bit m_ovf[3];

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      m_tick[i] = 1'b0;
      m_ovf[i]  = 1'b0;
      if (rst) begin
        m_count[i] = 0;
        m_phase[i] = 0;
      end else if (load) begin
        m_count[i] = int'(din);
        m_phase[i] = 0;
      end else if (en) begin
        m_phase[i] = m_phase[i] + 1;
        if (m_phase[i] == div_p[i]) begin
          m_phase[i] = 0;
          m_tick[i]  = 1'b1;
          if (dir) begin
            if (m_count[i] + 1 > 255) begin
              m_ovf[i]   = 1'b1;
              m_count[i] = sat_p[i] ? 255 : 0;
            end else m_count[i] = m_count[i] + 1;
          end else begin
            if (m_count[i] - 1 < 0) begin
              m_ovf[i]   = 1'b1;
              m_count[i] = sat_p[i] ? 0 : 255;
            end else m_count[i] = m_count[i] - 1;
          end
        end
      end
    end
  end

  // ---------------- compare process (every cycle, opposite edge) ----------------
  always @(negedge clk) begin
    if (cmp_on) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("u%0d count", i), 32'(a_count[i]), 32'(m_count[i]));
        chk($sformatf("u%0d leds", i),  32'(a_leds[i]),  32'(m_count[i] >> (8 - nl_p[i])));
        chk($sformatf("u%0d tick", i),  32'(a_tick[i]),  32'(m_tick[i]));
        chk($sformatf("u%0d ovf", i),   32'(a_ovf[i]),   32'(m_ovf[i]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic r, input logic e, input logic d, input logic l, input logic [7:0] v);
    rst = r; en = e; dir = d; load = l; din = v;
  endtask

  // ---------------- directed + random stimulus ----------------
  int ovf_seen;
  logic [7:0] din_tab[6] = '{8'h00, 8'hFF, 8'hFE, 8'h01, 8'h7F, 8'h80};

  initial begin
    // reset state
    drive(1, 1, 1, 1, 8'hA5);
    cyc(1);
    cmp_on = 1'b1;
    chk("reset count", 32'(if0.count), 32'h00);
    chk("reset tick/ovf", {30'd0, if0.tick, if0.ovf}, 32'h0);
    chk("reset leds", 32'(if0.leds), 32'h00);

    // 1: basic count, first step on 4th enabled edge
    drive(0, 1, 1, 0, 8'h00);
    cyc(3);
    chk("basic pre-step count", 32'(if0.count), 32'h00);
    chk("basic pre-step tick", 32'(if0.tick), 32'h0);
    cyc(1);
    chk("basic first step count", 32'(if0.count), 32'h01);
    chk("basic first step tick", 32'(if0.tick), 32'h1);
    ovf_seen = 0;
    for (int k = 0; k < 1020; k++) begin
      cyc(1);
      if (if0.ovf === 1'b1) ovf_seen++;
    end
    chk("basic 1024 edges count", 32'(if0.count), 32'h00);
    chk("basic single ovf", 32'(ovf_seen), 32'd1);
    chk("basic wrap ovf pulse", 32'(if0.ovf), 32'h1);
    chk("model after 1024", 32'(m_count[0]), 32'h00);

    // 2: load mid-prescale
    cyc(2);
    chk("model pre=2", 32'(m_phase[0]), 32'd2);
    drive(0, 1, 1, 1, 8'hFE);
    cyc(1);
    chk("load count", 32'(if0.count), 32'hFE);
    chk("load tick", 32'(if0.tick), 32'h0);
    drive(0, 1, 1, 0, 8'h00);
    cyc(3);
    chk("load hold", 32'(if0.count), 32'hFE);
    cyc(1);
    chk("load +4", 32'(if0.count), 32'hFF);
    chk("leds all on", 32'(if0.leds), 32'h1F);
    cyc(4);
    chk("load wrap count", 32'(if0.count), 32'h00);
    chk("load wrap ovf", 32'(if0.ovf), 32'h1);
    cyc(1);
    chk("ovf one cycle", 32'(if0.ovf), 32'h0);

    // 3: down wrap and direction change between steps
    drive(0, 1, 0, 1, 8'h00);
    cyc(1);
    drive(0, 1, 0, 0, 8'h00);
    cyc(4);
    chk("down wrap count", 32'(if0.count), 32'hFF);
    chk("down wrap ovf", 32'(if0.ovf), 32'h1);
    cyc(2);
    dir = 1'b1;
    cyc(1);
    chk("dir flip no extra step", 32'(if0.tick), 32'h0);
    cyc(1);
    chk("up wrap count", 32'(if0.count), 32'h00);
    chk("up wrap ovf", 32'(if0.ovf), 32'h1);

    // 4: saturation on u1
    drive(0, 1, 1, 1, 8'hFF);
    cyc(1);
    load = 1'b0;
    cyc(4);
    chk("sat up count", 32'(if1.count), 32'hFF);
    chk("sat up tick+ovf", {30'd0, if1.tick, if1.ovf}, 32'h3);
    cyc(1);
    chk("sat tick low", 32'(if1.tick), 32'h0);
    cyc(3);
    chk("sat repeat ovf", {30'd0, if1.tick, if1.ovf}, 32'h3);
    drive(0, 1, 0, 1, 8'h00);
    cyc(1);
    load = 1'b0;
    cyc(4);
    chk("sat down count", 32'(if1.count), 32'h00);
    chk("sat down ovf", 32'(if1.ovf), 32'h1);

    // 5: enable gating at pre=2
    drive(0, 1, 1, 1, 8'h10);
    cyc(1);
    load = 1'b0;
    cyc(2);
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc(1);
      chk("gated hold", {23'd0, if0.tick, if0.count}, 32'h010);
    end
    en = 1'b1;
    cyc(1);
    chk("resume 1st edge", {23'd0, if0.tick, if0.count}, 32'h010);
    cyc(1);
    chk("resume 2nd edge", {23'd0, if0.tick, if0.count}, 32'h111);

    // 6: reset priority over load
    cyc(1);
    drive(1, 1, 1, 1, 8'hA5);
    cyc(1);
    chk("rst over load", {14'd0, if0.tick, if0.ovf, if0.leds, if0.count}, 32'h0);
    drive(0, 0, 1, 1, 8'hA5);
    cyc(1);
    load = 1'b0;
    chk("load A5 leds", 32'(if0.leds), 32'h14);
    chk("load A5 count", 32'(if0.count), 32'hA5);

    // random phase, model-checked every cycle
    for (int k = 0; k < 3000; k++) begin
      rst  = ($urandom_range(0, 99) == 0);
      load = ($urandom_range(0, 29) == 0);
      en   = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) dir = ~dir;
      din  = ($urandom_range(0, 1) == 0) ? din_tab[$urandom_range(0, 5)] : 8'($urandom_range(0, 255));
      cyc(1);
    end

    cmp_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
